// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch program counter: opcode encodings
// and width helpers used by the sequencer, its bus interface and the op decoder.
package pc_sequencer_pkg;

  localparam int OP_WIDTH = 3;

  // Codes 000/001/011 keep the meaning of the legacy 2-bit flag PC.
  typedef enum logic [OP_WIDTH-1:0] {
    OP_INC   = 3'b000,
    OP_JUMP  = 3'b001,
    OP_BRNCH = 3'b010,
    OP_HOLD  = 3'b011,
    OP_CALL  = 3'b100,
    OP_RET   = 3'b101,
    OP_RSVD6 = 3'b110,
    OP_RSVD7 = 3'b111
  } op_e;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the op decoder (master) and the PC sequencer (slave).
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int STACK_DEPTH = 8
);

  localparam int SP_WIDTH = sp_width(STACK_DEPTH);

  logic                  stall;
  logic [OP_WIDTH-1:0]   op;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] add_inst;
  logic [SP_WIDTH-1:0]   sp;
  logic                  stk_full;
  logic                  stk_empty;
  logic                  ovf_err;
  logic                  unf_err;

  modport master (
    output stall, op, target,
    input  add_inst, sp, stk_full, stk_empty, ovf_err, unf_err
  );

  modport slave (
    input  stall, op, target,
    output add_inst, sp, stk_full, stk_empty, ovf_err, unf_err
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET; silently ignores a push when full and a pop
// when empty, leaving the error reporting to the caller.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp_q;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp    = sp_q;
  assign dout  = mem[IDXW'(sp_q - SPW'(1))];

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  // NOTE: the storage array has no reset; only sp is cleared, so entries above sp
  // are never read and the array can map onto plain registers or distributed RAM.
  always_ff @(posedge clock) begin
    if (!reset && push && !full) begin
      mem[IDXW'(sp_q)] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit for instruction fetch: increment, jump, relative branch,
// hold and CALL/RET through a return-address stack, with sticky stack error flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INC_STEP     = 1
) (
  input logic          clock,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INC_STEP);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] stk_top;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ovf_q;
  logic                  unf_q;

  ret_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + STEP),
    .dout  (stk_top),
    .sp    (bus.sp),
    .full  (bus.stk_full),
    .empty (bus.stk_empty)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!bus.stall) begin
      unique case (op_e'(bus.op))
        OP_INC:   pc_next = pc_q + STEP;
        OP_JUMP:  pc_next = bus.target;
        // Two's-complement offset: a plain modulo add gives the signed result.
        OP_BRNCH: pc_next = pc_q + bus.target;
        OP_CALL: begin
          if (bus.stk_full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = bus.target;
          end
        end
        OP_RET: begin
          if (bus.stk_empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stk_top;
          end
        end
        default: pc_next = pc_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign bus.add_inst = pc_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (10-bit/8-deep and 16-bit/2-deep) run the
// same directed op sequence against a behavioural model, plus literal spot checks.
module tb_pc_sequencer;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BRN = 3'd2, HLD = 3'd3,
                         CAL = 3'd4, RET = 3'd5;

  logic       clock;
  logic       reset;
  logic       stall;
  logic [2:0] op;
  int         target_a;
  int         target_b;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.ADDR_WIDTH(10), .STACK_DEPTH(8)) bus_a ();
  pc_sequencer_if #(.ADDR_WIDTH(16), .STACK_DEPTH(2)) bus_b ();

  assign bus_a.stall  = stall;
  assign bus_a.op     = op;
  assign bus_a.target = target_a[9:0];
  assign bus_b.stall  = stall;
  assign bus_b.op     = op;
  assign bus_b.target = target_b[15:0];

  pc_sequencer #(.ADDR_WIDTH(10), .STACK_DEPTH(8)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  pc_sequencer #(.ADDR_WIDTH(16), .STACK_DEPTH(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: PC as an integer modulo 2^width, stack as an array plus count.
  int m_pc  [2];
  int m_sp  [2];
  int m_stk [2][8];
  bit m_ovf [2];
  bit m_unf [2];
  bit model_valid = 1'b0;

  always @(posedge clock) begin : model
    int mask;
    int depth;
    int tgt;
    for (int i = 0; i < 2; i++) begin
      mask  = (i == 0) ? 'h3FF : 'hFFFF;
      depth = (i == 0) ? 8 : 2;
      tgt   = (i == 0) ? target_a : target_b;
      if (reset) begin
        m_pc[i]  <= 0;
        m_sp[i]  <= 0;
        m_ovf[i] <= 1'b0;
        m_unf[i] <= 1'b0;
      end else if (!stall) begin
        case (op)
          INC: m_pc[i] <= (m_pc[i] + 1) & mask;
          JMP: m_pc[i] <= tgt & mask;
          BRN: m_pc[i] <= (m_pc[i] + tgt) & mask;
          CAL: begin
            if (m_sp[i] == depth) begin
              m_ovf[i] <= 1'b1;
            end else begin
              m_stk[i][m_sp[i]] <= (m_pc[i] + 1) & mask;
              m_sp[i]           <= m_sp[i] + 1;
              m_pc[i]           <= tgt & mask;
            end
          end
          RET: begin
            if (m_sp[i] == 0) begin
              m_unf[i] <= 1'b1;
            end else begin
              m_sp[i] <= m_sp[i] - 1;
              m_pc[i] <= m_stk[i][m_sp[i] - 1];
            end
          end
          default: ;
        endcase
      end
    end
    if (reset) model_valid <= 1'b1;
  end

  always @(negedge clock) begin : compare
    if (model_valid) begin
      check("cmp_a_pc",    32'(bus_a.add_inst),  32'(m_pc[0]));
      check("cmp_a_sp",    32'(bus_a.sp),        32'(m_sp[0]));
      check("cmp_a_full",  32'(bus_a.stk_full),  32'(m_sp[0] == 8));
      check("cmp_a_empty", 32'(bus_a.stk_empty), 32'(m_sp[0] == 0));
      check("cmp_a_ovf",   32'(bus_a.ovf_err),   32'(m_ovf[0]));
      check("cmp_a_unf",   32'(bus_a.unf_err),   32'(m_unf[0]));
      check("cmp_b_pc",    32'(bus_b.add_inst),  32'(m_pc[1]));
      check("cmp_b_sp",    32'(bus_b.sp),        32'(m_sp[1]));
      check("cmp_b_full",  32'(bus_b.stk_full),  32'(m_sp[1] == 2));
      check("cmp_b_empty", 32'(bus_b.stk_empty), 32'(m_sp[1] == 0));
      check("cmp_b_ovf",   32'(bus_b.ovf_err),   32'(m_ovf[1]));
      check("cmp_b_unf",   32'(bus_b.unf_err),   32'(m_unf[1]));
    end
  end

  // Drive one op for one cycle; returns at the following negedge, after it took effect.
  task automatic step(input logic [2:0] o, input int ta, input int tb, input logic st);
    op       = o;
    target_a = ta;
    target_b = tb;
    stall    = st;
    @(negedge clock);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1;
    stall = 1'b0;
    op = HLD;
    target_a = 0;
    target_b = 0;
    @(negedge clock);
    step(HLD, 0, 0, 1'b0);
    reset = 1'b0;

    // T1: reset state, increments, hold
    check("t1_rst_pc_a", 32'(bus_a.add_inst), 32'h0);
    check("t1_rst_pc_b", 32'(bus_b.add_inst), 32'h0);
    check("t1_rst_empty_a", 32'(bus_a.stk_empty), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      step(INC, 0, 0, 1'b0);
      check("t1_inc_pc_a", 32'(bus_a.add_inst), 32'(k));
    end
    step(HLD, 0, 0, 1'b0);
    step(HLD, 0, 0, 1'b0);
    check("t1_hold_pc_a", 32'(bus_a.add_inst), 32'h5);
    check("t1_hold_pc_b", 32'(bus_b.add_inst), 32'h5);

    // T2: jump near the top, wrap, signed branches
    step(JMP, 'h3FE, 'hFFFE, 1'b0);
    check("t2_jump_pc_a", 32'(bus_a.add_inst), 32'h3FE);
    step(INC, 0, 0, 1'b0);
    check("t2_inc_pc_a", 32'(bus_a.add_inst), 32'h3FF);
    check("t2_inc_pc_b", 32'(bus_b.add_inst), 32'hFFFF);
    step(INC, 0, 0, 1'b0);
    check("t2_wrap_pc_a", 32'(bus_a.add_inst), 32'h000);
    check("t2_wrap_pc_b", 32'(bus_b.add_inst), 32'h0000);
    step(BRN, 'h3FC, 'hFFFC, 1'b0);
    check("t2_brn_neg_pc_a", 32'(bus_a.add_inst), 32'h3FC);
    check("t2_brn_neg_pc_b", 32'(bus_b.add_inst), 32'hFFFC);
    step(BRN, 'h008, 'h0008, 1'b0);
    check("t2_brn_pos_pc_a", 32'(bus_a.add_inst), 32'h004);
    step(3'd6, 'h123, 'h123, 1'b0);
    step(3'd7, 'h123, 'h123, 1'b0);
    check("t2_rsvd_pc_a", 32'(bus_a.add_inst), 32'h004);

    // T3: nested call and return
    step(JMP, 'h010, 'h010, 1'b0);
    step(CAL, 'h100, 'h100, 1'b0);
    check("t3_call1_pc_a", 32'(bus_a.add_inst), 32'h100);
    check("t3_call1_sp_a", 32'(bus_a.sp), 32'h1);
    step(CAL, 'h200, 'h200, 1'b0);
    check("t3_call2_pc_a", 32'(bus_a.add_inst), 32'h200);
    check("t3_call2_full_b", 32'(bus_b.stk_full), 32'h1);
    step(RET, 0, 0, 1'b0);
    check("t3_ret1_pc_a", 32'(bus_a.add_inst), 32'h101);
    check("t3_ret1_sp_a", 32'(bus_a.sp), 32'h1);
    step(RET, 0, 0, 1'b0);
    check("t3_ret2_pc_a", 32'(bus_a.add_inst), 32'h011);
    check("t3_ret2_pc_b", 32'(bus_b.add_inst), 32'h011);
    check("t3_ret2_empty_a", 32'(bus_a.stk_empty), 32'h1);

    // T4: fill the stack, then overflow
    for (int k = 0; k < 8; k++) step(CAL, 'h20 + k, 'h20 + k, 1'b0);
    check("t4_fill_sp_a", 32'(bus_a.sp), 32'h8);
    check("t4_fill_full_a", 32'(bus_a.stk_full), 32'h1);
    check("t4_fill_pc_a", 32'(bus_a.add_inst), 32'h027);
    check("t4_ovf_pc_b", 32'(bus_b.add_inst), 32'h0021);
    check("t4_ovf_flag_b", 32'(bus_b.ovf_err), 32'h1);
    step(CAL, 'h055, 'h055, 1'b0);
    check("t4_ovf_pc_a", 32'(bus_a.add_inst), 32'h027);
    check("t4_ovf_sp_a", 32'(bus_a.sp), 32'h8);
    check("t4_ovf_flag_a", 32'(bus_a.ovf_err), 32'h1);
    step(INC, 0, 0, 1'b0);
    step(INC, 0, 0, 1'b0);
    check("t4_sticky_pc_a", 32'(bus_a.add_inst), 32'h029);
    check("t4_sticky_ovf_a", 32'(bus_a.ovf_err), 32'h1);

    // T5: underflow, then stall with CALL and RET pending
    reset = 1'b1;
    step(HLD, 0, 0, 1'b0);
    reset = 1'b0;
    check("t5_rst_ovf_a", 32'(bus_a.ovf_err), 32'h0);
    step(JMP, 'h0AB, 'h0AB, 1'b0);
    step(RET, 0, 0, 1'b0);
    check("t5_unf_pc_a", 32'(bus_a.add_inst), 32'h0AB);
    check("t5_unf_flag_a", 32'(bus_a.unf_err), 32'h1);
    check("t5_unf_flag_b", 32'(bus_b.unf_err), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step(CAL, 'h155, 'h155, 1'b1);
      check("t5_stall_pc_a", 32'(bus_a.add_inst), 32'h0AB);
      check("t5_stall_sp_a", 32'(bus_a.sp), 32'h0);
    end
    step(CAL, 'h155, 'h155, 1'b0);
    check("t5_legal_pc_a", 32'(bus_a.add_inst), 32'h155);
    check("t5_legal_unf_a", 32'(bus_a.unf_err), 32'h1);
    step(RET, 0, 0, 1'b1);
    check("t5_stall_ret_sp_a", 32'(bus_a.sp), 32'h1);

    // T6: reset on the same edge as a CALL with sp=3
    step(CAL, 'h040, 'h040, 1'b0);
    step(CAL, 'h060, 'h060, 1'b0);
    check("t6_pre_sp_a", 32'(bus_a.sp), 32'h3);
    reset = 1'b1;
    step(CAL, 'h300, 'h300, 1'b1);
    reset = 1'b0;
    check("t6_rst_pc_a", 32'(bus_a.add_inst), 32'h0);
    check("t6_rst_sp_a", 32'(bus_a.sp), 32'h0);
    check("t6_rst_ovf_b", 32'(bus_b.ovf_err), 32'h0);
    check("t6_rst_unf_a", 32'(bus_a.unf_err), 32'h0);
    step(INC, 0, 0, 1'b0);
    check("t6_post_pc_a", 32'(bus_a.add_inst), 32'h1);
    step(HLD, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
